test_slave: RTL and testbench
=============================

Name: test_slave

Overview:
- AXI4 full-protocol slave backed by a 16 x 32-bit register memory (64-byte space, 6-bit byte address).
- Serves as a bus-functional target for verifying AXI masters and interconnect.
- Read and write channels are independent: one read burst and one write burst may be in flight at the same time.

Parameters:
- ID_W, 6, width of ARID/AWID/RID/BID.
- ADDR_W, 6, byte-address width; memory depth is 2^(ADDR_W-2) words.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- S_AXI_ARVALID/ARREADY  in/out  1/1  read-address handshake.
- S_AXI_ARID  in  6  read burst ID.
- S_AXI_ARADDR  in  6  read start byte address.
- S_AXI_ARLEN  in  8  read beats minus 1.
- S_AXI_ARSIZE  in  3  read beat size.
- S_AXI_ARBURST  in  2  read burst type (0 FIXED, 1 INCR, 2 WRAP).
- S_AXI_RVALID/RREADY  out/in  1/1  read-data handshake.
- S_AXI_RID  out  6  read response ID.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RLAST  out  1  final read beat.
- S_AXI_AWVALID/AWREADY, AWID, AWADDR, AWLEN, AWSIZE, AWBURST  same widths and meanings as the read-address channel, for writes.
- S_AXI_WVALID/WREADY  in/out  1/1  write-data handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WLAST  in  1  final write beat.
- S_AXI_BVALID/BREADY  out/in  1/1  write-response handshake.
- S_AXI_BID  out  6  write response ID.
- S_AXI_BRESP  out  2  write response.

Behaviour:
- Reset: all memory words = 0; RVALID, RLAST, WREADY, BVALID = 0; ARREADY, AWREADY = 0; RID, BID, RDATA, RRESP, BRESP = 0; both FSMs go to IDLE.
- ARREADY and AWREADY rise one cycle after reset deasserts.
- Read FSM, IDLE -> RDATA:
  - ARREADY = 1 only in IDLE.
  - On ARVALID & ARREADY: latch ID, address, len, burst; beat counter = 0.
  - RVALID = 1 starting the next cycle.
  - RDATA = mem[addr[5:2]], driven from current registers, so a write committed in a prior cycle is visible.
  - RID = latched ID; RRESP = 0 (OKAY); RLAST = 1 when counter == len.
- Read FSM, beat advance:
  - RVALID & RREADY advances address and counter.
  - On the last beat, return to IDLE; ARREADY = 1 the following cycle.
  - RVALID and all R outputs hold stable while RREADY = 0.
- Write FSM, IDLE -> WDATA -> WRESP:
  - AWREADY = 1 only in IDLE; on AW handshake, latch fields and enter WDATA.
  - In WDATA, WREADY = 1. Each WVALID & WREADY writes WDATA into mem[addr[5:2]], updating byte i only when WSTRB[i] = 1, then advances the address.
  - Burst ends when counter == len, regardless of WLAST; then enter WRESP.
- Write FSM, response:
  - In WRESP: BVALID = 1, BID = latched AWID, held until BREADY.
  - BRESP = 0, or 2 (SLVERR) if WLAST did not coincide exactly with the final beat (early or missing). Data is still written in that case.
  - Return to IDLE after the B handshake.
- Address generation (word granularity, ADDR[1:0] ignored, beat size treated as 4 bytes):
  - FIXED: address constant.
  - INCR or reserved type 3: addr + 4, modulo 64.
  - WRAP: wrap boundary = (len+1)*4 bytes, aligned down; address wraps within it. Len of 1/3/7/15 is legal; other lengths are handled as INCR.
- Bursts longer than 16 beats wrap modulo 64 bytes.
- Simultaneous read and write to the same word in one cycle: read returns the old value; the new value is visible from the next beat.
- Reset mid-burst aborts both FSMs immediately and returns all outputs to their reset values.

Optional Feature:
- Macro TEST_SLAVE_RESP_CHECK_EN.
- Defined:
  - AxSIZE != 2 or AxBURST == 3 yields SLVERR (2) on every R beat / on B.
  - Writes in such a burst are suppressed; reads still return memory data.
- Undefined: size and burst type are not checked; only the WLAST-mismatch SLVERR remains.

Test Plan:
- Single write then read:
  - AW addr 0x08, len 0, WDATA 0xDEADBEEF, WSTRB 0xF, WLAST 1 -> BVALID with BID = AWID, BRESP 0.
  - AR addr 0x08, len 0 -> RDATA 0xDEADBEEF, RLAST 1, RRESP 0.
- INCR burst:
  - Write len 3 from 0x00 with 1,2,3,4.
  - Read len 3 from 0x00 -> 1,2,3,4, RLAST only on beat 4.
- WRAP burst:
  - Read len 3 from 0x08 -> words at 0x08, 0x0C, 0x00, 0x04.
  - FIXED len 2 at 0x04 -> same word three times.
- Strobe: word 0x10 = 0xFFFFFFFF; write 0x12345678 with WSTRB 0x5 -> read 0xFF34FF78.
- Backpressure: hold RREADY = 0 for 3 cycles mid-burst -> RDATA/RLAST/RVALID stable. Hold BREADY = 0 -> BVALID held, AWREADY stays 0.
- Errors and reset:
  - WLAST asserted on beat 2 of a len-3 burst -> BRESP 2.
  - Reset asserted mid-read -> RVALID = 0 next cycle; memory reads back 0.

Source files
------------

// File: rtl/test_slave.sv
// test_slave: AXI4 full-protocol slave target backed by a 2^(ADDR_W-2) x DATA_W
// register memory. Independent read and write FSMs allow one read burst and one
// write burst in flight at the same time.
// Optional feature macro: TEST_SLAVE_RESP_CHECK_EN. When defined, bursts with
// AxSIZE != 2 or AxBURST == 3 answer SLVERR and their writes are suppressed.
module test_slave #(
  parameter int ID_W   = 6,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  // read address channel
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  input  logic [ID_W-1:0]     S_AXI_ARID,
  input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic [7:0]          S_AXI_ARLEN,
  input  logic [2:0]          S_AXI_ARSIZE,
  input  logic [1:0]          S_AXI_ARBURST,
  // read data channel
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY,
  output logic [ID_W-1:0]     S_AXI_RID,
  output logic [DATA_W-1:0]   S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RLAST,
  // write address channel
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [ID_W-1:0]     S_AXI_AWID,
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic [7:0]          S_AXI_AWLEN,
  input  logic [2:0]          S_AXI_AWSIZE,
  input  logic [1:0]          S_AXI_AWBURST,
  // write data channel
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  input  logic [DATA_W-1:0]   S_AXI_WDATA,
  input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
  input  logic                S_AXI_WLAST,
  // write response channel
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  output logic [ID_W-1:0]     S_AXI_BID,
  output logic [1:0]          S_AXI_BRESP
);

  localparam int WA     = ADDR_W - 2;   // word-address width
  localparam int DEPTH  = 1 << WA;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef enum logic       {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // Word address of the beat after addr. WRAP only for power-of-two lengths;
  // any other WRAP length, INCR and reserved type 3 simply increment.
  function automatic logic [WA-1:0] next_addr(input logic [WA-1:0] addr,
                                              input logic [7:0]    len,
                                              input logic [1:0]    burst);
    logic [WA-1:0] inc;
    logic [WA-1:0] mask;
    inc       = addr + WA'(1);
    mask      = len[WA-1:0];
    next_addr = inc;
    if (burst == BURST_FIXED)
      next_addr = addr;
    else if (burst == BURST_WRAP &&
             (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      next_addr = (addr & ~mask) | (inc & mask);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic              out_en;

  r_state_t    r_state, r_state_nxt;
  logic [ID_W-1:0] r_id;
  logic [WA-1:0]   r_addr;
  logic [7:0]      r_len, r_cnt;
  logic [1:0]      r_burst;
  logic            r_err;

  w_state_t    w_state, w_state_nxt;
  logic [ID_W-1:0] w_id;
  logic [WA-1:0]   w_addr;
  logic [7:0]      w_len, w_cnt;
  logic [1:0]      w_burst;
  logic            w_bad, w_last_err;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs, mem_we;
  logic r_err_in, w_bad_in;

  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign r_hs   = S_AXI_RVALID & S_AXI_RREADY;
  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign b_hs   = S_AXI_BVALID & S_AXI_BREADY;
  assign mem_we = w_hs & ~w_bad;

`ifdef TEST_SLAVE_RESP_CHECK_EN
  assign r_err_in = (S_AXI_ARSIZE != 3'd2) || (S_AXI_ARBURST == 2'd3);
  assign w_bad_in = (S_AXI_AWSIZE != 3'd2) || (S_AXI_AWBURST == 2'd3);
  logic unused_bits;
  assign unused_bits = ^{S_AXI_ARADDR[1:0], S_AXI_AWADDR[1:0]};
`else
  assign r_err_in = 1'b0;
  assign w_bad_in = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{S_AXI_ARADDR[1:0], S_AXI_AWADDR[1:0],
                         S_AXI_ARSIZE, S_AXI_AWSIZE};
`endif

  // Ready enable: holds both address channels off until the cycle after reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) out_en <= 1'b0;
    else       out_en <= 1'b1;
  end

  // Register memory with per-byte strobed writes.
  // NOTE: the memory is reset because the slave must read back zero after any reset; it maps to flops, not RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < STRB_W; b++)
        if (S_AXI_WSTRB[b]) mem[w_addr][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
    end
  end

  // ---------------- read channel ----------------

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_state_nxt;
  end

  // Read FSM next-state logic.
  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs && r_cnt == r_len) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read burst context: latched on AR handshake, advanced on each R handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
    end else if (ar_hs) begin
      r_id    <= S_AXI_ARID;
      r_addr  <= S_AXI_ARADDR[ADDR_W-1:2];
      r_len   <= S_AXI_ARLEN;
      r_cnt   <= '0;
      r_burst <= S_AXI_ARBURST;
      r_err   <= r_err_in;
    end else if (r_hs) begin
      r_addr  <= next_addr(r_addr, r_len, r_burst);
      r_cnt   <= r_cnt + 8'd1;
    end
  end

  // Read channel outputs; data comes straight from the memory registers.
  always_comb begin
    S_AXI_ARREADY = (r_state == R_IDLE) && out_en;
    S_AXI_RVALID  = (r_state == R_DATA);
    S_AXI_RLAST   = (r_state == R_DATA) && (r_cnt == r_len);
    S_AXI_RID     = r_id;
    S_AXI_RDATA   = mem[r_addr];
    S_AXI_RRESP   = r_err ? RESP_SLVERR : RESP_OKAY;
  end

  // ---------------- write channel ----------------

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_state_nxt;
  end

  // Write FSM next-state logic; the burst ends on the beat count, not on WLAST.
  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && w_cnt == w_len) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write burst context and WLAST consistency tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_id       <= '0;
      w_addr     <= '0;
      w_len      <= '0;
      w_cnt      <= '0;
      w_burst    <= '0;
      w_bad      <= 1'b0;
      w_last_err <= 1'b0;
    end else if (aw_hs) begin
      w_id       <= S_AXI_AWID;
      w_addr     <= S_AXI_AWADDR[ADDR_W-1:2];
      w_len      <= S_AXI_AWLEN;
      w_cnt      <= '0;
      w_burst    <= S_AXI_AWBURST;
      w_bad      <= w_bad_in;
      w_last_err <= 1'b0;
    end else if (w_hs) begin
      w_addr <= next_addr(w_addr, w_len, w_burst);
      w_cnt  <= w_cnt + 8'd1;
      if (S_AXI_WLAST != (w_cnt == w_len)) w_last_err <= 1'b1;
    end
  end

  // Write channel outputs.
  always_comb begin
    S_AXI_AWREADY = (w_state == W_IDLE) && out_en;
    S_AXI_WREADY  = (w_state == W_DATA);
    S_AXI_BVALID  = (w_state == W_RESP);
    S_AXI_BID     = w_id;
    S_AXI_BRESP   = (w_last_err || w_bad) ? RESP_SLVERR : RESP_OKAY;
  end

endmodule

// File: tb/tb_test_slave.sv
// tb_test_slave: directed and randomized AXI bursts against test_slave, checked
// against a word-array memory model with arithmetic burst address generation.
module tb_test_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [5:0]  arid, araddr, rid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic [31:0] rdata;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [5:0]  awid, awaddr, bid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  test_slave dut (
    .clk(clk), .reset(reset),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARID(arid),
    .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
    .S_AXI_ARBURST(arburst),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RID(rid),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWID(awid),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BID(bid),
    .S_AXI_BRESP(bresp)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ref_mem [16];
  logic [31:0] wd [$];
  logic [3:0]  ws [$];
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Byte address of beat i, straight from the burst rules.
  function automatic int beat_addr(input int start, input int len, input int burst, input int i);
    int s, bnd, base;
    s = start & ~3;
    if (burst == 0) return s;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      bnd  = (len + 1) * 4;
      base = (s / bnd) * bnd;
      return base + ((s - base) + 4 * i) % bnd;
    end
    return (s + 4 * i) % 64;
  endfunction

  function automatic logic [1:0] burst_resp(input int burst);
`ifdef TEST_SLAVE_RESP_CHECK_EN
    return (burst == 3) ? 2'd2 : 2'd0;
`else
    return (burst == 3) ? 2'd0 : 2'd0 + 2'(burst & 0);
`endif
  endfunction

  // Write burst using wd/ws; last_at is the beat index carrying WLAST (-1: none).
  task automatic axi_write(input logic [5:0] id, input int addr, input int len,
                           input int burst, input int last_at, input int b_delay);
    int n;
    logic [1:0] exp_resp;
    awid = id; awaddr = addr[5:0]; awlen = len[7:0]; awsize = 3'd2;
    awburst = burst[1:0]; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 100) begin tick(); n++; end
    check("aw_wait", 32'(n < 100), 1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_at);
      n = 0;
      while (wready !== 1'b1 && n < 100) begin tick(); n++; end
      check("w_wait", 32'(n < 100), 1);
      tick();
      if (burst_resp(burst) == 2'd0) begin
        int a;
        a = beat_addr(addr, len, burst, i) / 4;
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) ref_mem[a][8*b +: 8] = wd[i][8*b +: 8];
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (bvalid !== 1'b1 && n < 100) begin tick(); n++; end
    check("b_wait", 32'(n < 100), 1);
    for (int c = 0; c < b_delay; c++) begin
      check("b_hold_bvalid", bvalid, 1);
      check("b_hold_awready", awready, 0);
      tick();
    end
    exp_resp = (last_at != len) ? 2'd2 : burst_resp(burst);
    check("bid", bid, id);
    check("bresp", bresp, exp_resp);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("b_done_bvalid", bvalid, 0);
    check("b_done_awready", awready, 1);
  endtask

  // Read burst checked against the model; stall_at holds RREADY low 3 cycles on that beat.
  task automatic axi_read(input logic [5:0] id, input int addr, input int len,
                          input int burst, input int stall_at);
    int n;
    logic [31:0] exp;
    arid = id; araddr = addr[5:0]; arlen = len[7:0]; arsize = 3'd2;
    arburst = burst[1:0]; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 100) begin tick(); n++; end
    check("ar_wait", 32'(n < 100), 1);
    tick();
    arvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      n = 0;
      while (rvalid !== 1'b1 && n < 100) begin tick(); n++; end
      check("r_wait", 32'(n < 100), 1);
      exp = ref_mem[beat_addr(addr, len, burst, i) / 4];
      check("rdata", rdata, exp);
      check("rlast", rlast, 32'(i == len));
      check("rresp", rresp, burst_resp(burst));
      check("rid", rid, id);
      if (i == stall_at) begin
        for (int c = 0; c < 3; c++) begin
          tick();
          check("stall_rvalid", rvalid, 1);
          check("stall_rdata", rdata, exp);
          check("stall_rlast", rlast, 32'(i == len));
        end
      end
      last_rd = rdata;
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
    check("r_done_rvalid", rvalid, 0);
    check("r_done_arready", arready, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int burst, len, addr;
    reset = 1'b1;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (3) tick();

    // reset state
    check("rst_arready", arready, 0);
    check("rst_awready", awready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rid", rid, 0);
    check("rst_bid", bid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rresp", rresp, 0);
    check("rst_bresp", bresp, 0);
    reset = 1'b0;
    check("rel_arready_low", arready, 0);
    tick();
    check("rel_arready", arready, 1);
    check("rel_awready", awready, 1);

    // single write then read
    wd = '{32'hDEADBEEF}; ws = '{4'hF};
    axi_write(6'h15, 8, 0, 1, 0, 0);
    axi_read(6'h2A, 8, 0, 1, -1);
    check("single_rd", last_rd, 32'hDEADBEEF);

    // INCR burst
    wd = '{32'd1, 32'd2, 32'd3, 32'd4}; ws = '{4'hF, 4'hF, 4'hF, 4'hF};
    axi_write(6'h03, 0, 3, 1, 3, 0);
    axi_read(6'h04, 0, 3, 1, -1);
    check("incr_last", last_rd, 32'd4);

    // WRAP read from 0x08 -> 0x08, 0x0C, 0x00, 0x04
    axi_read(6'h05, 8, 3, 2, -1);
    check("wrap_last", last_rd, 32'd2);

    // FIXED read, same word three times
    axi_read(6'h06, 4, 2, 0, -1);
    check("fixed_last", last_rd, 32'd2);

    // strobes
    wd = '{32'hFFFFFFFF}; ws = '{4'hF};
    axi_write(6'h07, 16, 0, 1, 0, 0);
    wd = '{32'h12345678}; ws = '{4'h5};
    axi_write(6'h08, 16, 0, 1, 0, 0);
    axi_read(6'h09, 16, 0, 1, -1);
    check("strobe_rd", last_rd, 32'hFF34FF78);

    // backpressure on R and B
    axi_read(6'h0A, 0, 3, 1, 1);
    wd = '{32'hA5A5_0001}; ws = '{4'hF};
    axi_write(6'h0B, 20, 0, 1, 0, 3);

    // WLAST early and missing
    wd = '{32'h11, 32'h22, 32'h33, 32'h44}; ws = '{4'hF, 4'hF, 4'hF, 4'hF};
    axi_write(6'h0C, 32, 3, 1, 1, 0);
    axi_write(6'h0D, 48, 3, 1, -1, 0);
    axi_read(6'h0E, 32, 7, 1, -1);

    // randomized bursts, including lengths past 16 beats
    for (int k = 0; k < 12; k++) begin
      burst = $urandom_range(0, 3);
      len   = (burst == 2) ? (2 ** $urandom_range(1, 4)) - 1 : $urandom_range(0, 20);
      addr  = $urandom_range(0, 63);
      wd = {}; ws = {};
      for (int i = 0; i <= len; i++) begin
        wd.push_back($urandom);
        ws.push_back(4'($urandom_range(0, 15)));
      end
      axi_write(6'($urandom), addr, len, burst, len, 0);
      burst = $urandom_range(0, 3);
      len   = $urandom_range(0, 20);
      axi_read(6'($urandom), $urandom_range(0, 63), len, burst, -1);
    end

    // reset in the middle of a read burst
    arid = 6'h11; araddr = 6'h00; arlen = 8'd3; arsize = 3'd2; arburst = 2'd1;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("mid_rvalid", rvalid, 1);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    reset = 1'b1;
    tick();
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_rlast", rlast, 0);
    check("mid_rst_arready", arready, 0);
    check("mid_rst_rid", rid, 0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    tick();
    axi_read(6'h12, 0, 15, 1, -1);
    check("post_rst_rd", last_rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
